// File: rtl/vrf_bank_arbiter.sv
// rtl/vrf_bank_arbiter.sv - per-bank VRF SRAM access arbiter with read-return routing
module vrf_bank_arbiter #(
  parameter int NrRd        = 3,
  parameter int NrWr        = 2,
  parameter int NrBanks     = 4,
  parameter int AddrW       = 8,
  parameter int DataW       = 64,
  parameter int StarveLimit = 3
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NrRd-1:0]                               rd_req_i,
  input  logic [NrRd-1:0][AddrW-1:0]                    rd_addr_i,
  output logic [NrRd-1:0]                               rd_gnt_o,
  output logic [NrRd-1:0]                               rd_valid_o,
  output logic [NrRd-1:0][DataW-1:0]                    rd_data_o,
  input  logic [NrWr-1:0]                               wr_req_i,
  input  logic [NrWr-1:0][AddrW-1:0]                    wr_addr_i,
  input  logic [NrWr-1:0][DataW-1:0]                    wr_data_i,
  input  logic [NrWr-1:0][DataW/8-1:0]                  wr_be_i,
  output logic [NrWr-1:0]                               wr_gnt_o,
  output logic [NrBanks-1:0]                            bank_req_o,
  output logic [NrBanks-1:0]                            bank_we_o,
  output logic [NrBanks-1:0][AddrW-$clog2(NrBanks)-1:0] bank_addr_o,
  output logic [NrBanks-1:0][DataW-1:0]                 bank_wdata_o,
  output logic [NrBanks-1:0][DataW/8-1:0]               bank_be_o,
  input  logic [NrBanks-1:0][DataW-1:0]                 bank_rdata_i
);

  localparam int BankW   = $clog2(NrBanks);
  localparam int RowW    = AddrW - BankW;
  localparam int RdIdW   = (NrRd > 1) ? $clog2(NrRd) : 1;
  localparam int WrIdW   = (NrWr > 1) ? $clog2(NrWr) : 1;
  localparam int StarveW = $clog2(StarveLimit + 1);

  logic [NrBanks-1:0][RdIdW-1:0]   rd_ptr_q;
  logic [NrBanks-1:0][WrIdW-1:0]   wr_ptr_q;
  logic [NrBanks-1:0][StarveW-1:0] starve_q;
  logic [NrBanks-1:0]              tag1_vld_q, tag2_vld_q;
  logic [NrBanks-1:0][RdIdW-1:0]   tag1_id_q, tag2_id_q;

  logic [NrBanks-1:0]              rd_win_vld, wr_win_vld;
  logic [NrBanks-1:0][RdIdW-1:0]   rd_win;
  logic [NrBanks-1:0][WrIdW-1:0]   wr_win;
  logic [NrBanks-1:0]              sel_rd, sel_wr;
  int                              rd_idx, wr_idx;

  // Round-robin candidate search per bank, starting at that bank's pointer.
  always_comb begin
    rd_win_vld = '0;
    rd_win     = '0;
    wr_win_vld = '0;
    wr_win     = '0;
    rd_idx     = 0;
    wr_idx     = 0;
    for (int b = 0; b < NrBanks; b++) begin
      for (int k = 0; k < NrRd; k++) begin
        rd_idx = (int'(rd_ptr_q[b]) + k) % NrRd;
        if (!rd_win_vld[b] && rd_req_i[rd_idx] &&
            (rd_addr_i[rd_idx][BankW-1:0] == BankW'(b))) begin
          rd_win_vld[b] = 1'b1;
          rd_win[b]     = RdIdW'(rd_idx);
        end
      end
      for (int k = 0; k < NrWr; k++) begin
        wr_idx = (int'(wr_ptr_q[b]) + k) % NrWr;
        if (!wr_win_vld[b] && wr_req_i[wr_idx] &&
            (wr_addr_i[wr_idx][BankW-1:0] == BankW'(b))) begin
          wr_win_vld[b] = 1'b1;
          wr_win[b]     = WrIdW'(wr_idx);
        end
      end
    end
  end

  // Writes win until the bank's read side has lost StarveLimit cycles in a row.
  for (genvar b = 0; b < NrBanks; b++) begin : g_sel
    assign sel_rd[b] = rd_win_vld[b] &&
                       !(wr_win_vld[b] && (starve_q[b] < StarveW'(StarveLimit)));
    assign sel_wr[b] = wr_win_vld[b] && !sel_rd[b];
  end

  always_comb begin
    rd_gnt_o = '0;
    wr_gnt_o = '0;
    for (int b = 0; b < NrBanks; b++) begin
      if (sel_rd[b]) rd_gnt_o[rd_win[b]] = 1'b1;
      if (sel_wr[b]) wr_gnt_o[wr_win[b]] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_req_o   <= '0;
      bank_we_o    <= '0;
      bank_addr_o  <= '0;
      bank_wdata_o <= '0;
      bank_be_o    <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      starve_q     <= '0;
      tag1_vld_q   <= '0;
      tag1_id_q    <= '0;
      tag2_vld_q   <= '0;
      tag2_id_q    <= '0;
    end else begin
      for (int b = 0; b < NrBanks; b++) begin
        bank_req_o[b] <= sel_rd[b] | sel_wr[b];
        bank_we_o[b]  <= sel_wr[b];
        if (sel_wr[b]) begin
          bank_addr_o[b]  <= wr_addr_i[wr_win[b]][AddrW-1:BankW];
          bank_wdata_o[b] <= wr_data_i[wr_win[b]];
          bank_be_o[b]    <= wr_be_i[wr_win[b]];
          wr_ptr_q[b]     <= (wr_win[b] == WrIdW'(NrWr - 1)) ? '0 : wr_win[b] + 1'b1;
        end else if (sel_rd[b]) begin
          bank_addr_o[b]  <= rd_addr_i[rd_win[b]][AddrW-1:BankW];
          bank_wdata_o[b] <= '0;
          bank_be_o[b]    <= '0;
          rd_ptr_q[b]     <= (rd_win[b] == RdIdW'(NrRd - 1)) ? '0 : rd_win[b] + 1'b1;
        end else begin
          bank_addr_o[b]  <= '0;
          bank_wdata_o[b] <= '0;
          bank_be_o[b]    <= '0;
        end

        if (sel_rd[b]) begin
          starve_q[b] <= '0;
        end else if (sel_wr[b] && rd_win_vld[b] &&
                     (starve_q[b] != StarveW'(StarveLimit))) begin
          starve_q[b] <= starve_q[b] + 1'b1;
        end

        tag1_vld_q[b] <= sel_rd[b];
        tag1_id_q[b]  <= sel_rd[b] ? rd_win[b] : '0;
        tag2_vld_q[b] <= tag1_vld_q[b];
        tag2_id_q[b]  <= tag1_id_q[b];
      end
    end
  end

  // Data-stage tags line up with the SRAM read data of the same bank.
  always_comb begin
    rd_valid_o = '0;
    rd_data_o  = '0;
    for (int b = 0; b < NrBanks; b++) begin
      if (tag2_vld_q[b]) begin
        rd_valid_o[tag2_id_q[b]] = 1'b1;
        rd_data_o[tag2_id_q[b]]  = bank_rdata_i[b];
      end
    end
  end

endmodule

// File: tb/tb_vrf_bank_arbiter.sv
// tb/tb_vrf_bank_arbiter.sv - directed bench for vrf_bank_arbiter with SRAM model and read scoreboard
module tb_vrf_bank_arbiter;

  localparam int NrRd    = 4;
  localparam int NrWr    = 2;
  localparam int NrBanks = 4;
  localparam int AddrW   = 8;
  localparam int DataW   = 64;
  localparam int BeW     = DataW / 8;
  localparam int RowW    = AddrW - 2;

  typedef struct packed {
    int          due;
    logic [63:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [NrRd-1:0]                 rd_req, rd_gnt, rd_valid;
  logic [NrRd-1:0][AddrW-1:0]      rd_addr;
  logic [NrRd-1:0][DataW-1:0]      rd_data;
  logic [NrWr-1:0]                 wr_req, wr_gnt;
  logic [NrWr-1:0][AddrW-1:0]      wr_addr;
  logic [NrWr-1:0][DataW-1:0]      wr_data;
  logic [NrWr-1:0][BeW-1:0]        wr_be;
  logic [NrBanks-1:0]              bank_req, bank_we;
  logic [NrBanks-1:0][RowW-1:0]    bank_addr;
  logic [NrBanks-1:0][DataW-1:0]   bank_wdata, bank_rdata;
  logic [NrBanks-1:0][BeW-1:0]     bank_be;

  logic [DataW-1:0] mem [NrBanks][1 << RowW];
  logic             mem_init = 1'b0;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  exp_t        sb [NrRd][$];
  logic [63:0] exp_data [NrRd];
  logic [63:0] w;

  vrf_bank_arbiter #(
    .NrRd(NrRd), .NrWr(NrWr), .NrBanks(NrBanks),
    .AddrW(AddrW), .DataW(DataW), .StarveLimit(3)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .wr_be_i(wr_be), .wr_gnt_o(wr_gnt),
    .bank_req_o(bank_req), .bank_we_o(bank_we), .bank_addr_o(bank_addr),
    .bank_wdata_o(bank_wdata), .bank_be_o(bank_be), .bank_rdata_i(bank_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] init_word(input logic [7:0] a);
    return {16'hC0DE, a, 8'h5A, 24'h13579B, ~a};
  endfunction

  // Single-port SRAM per bank: one-cycle read latency, byte-masked writes.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int b = 0; b < NrBanks; b++)
        for (int r = 0; r < (1 << RowW); r++)
          mem[b][r] <= init_word(8'(r * NrBanks + b));
      bank_rdata <= '0;
      mem_init   <= 1'b1;
    end else begin
      for (int b = 0; b < NrBanks; b++) begin
        if (bank_req[b]) begin
          if (bank_we[b]) begin
            for (int k = 0; k < BeW; k++)
              if (bank_be[b][k]) mem[b][bank_addr[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
          end else begin
            bank_rdata[b] <= mem[b][bank_addr[b]];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_returns();
    exp_t e;
    for (int i = 0; i < NrRd; i++) begin
      if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
        e = sb[i].pop_front();
        chk($sformatf("rd_valid[%0d]@%0d", i, cyc), 64'(rd_valid[i]), 64'd1);
        chk($sformatf("rd_data[%0d]@%0d", i, cyc), rd_data[i], e.data);
      end else begin
        chk($sformatf("rd_idle_valid[%0d]@%0d", i, cyc), 64'(rd_valid[i]), 64'd0);
        chk($sformatf("rd_idle_data[%0d]@%0d", i, cyc), rd_data[i], 64'd0);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_returns();
  endtask

  task automatic idle();
    rd_req = '0;
    wr_req = '0;
  endtask

  task automatic rd(input int i, input logic [7:0] a);
    rd_req[i]   = 1'b1;
    rd_addr[i]  = a;
    exp_data[i] = init_word(a);
  endtask

  task automatic wr(input int i, input logic [7:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_req[i]  = 1'b1;
    wr_addr[i] = a;
    wr_data[i] = d;
    wr_be[i]   = be;
  endtask

  // Checks this cycle's combinational grants, books expected returns, then advances.
  task automatic cycle(input string tag, input logic [3:0] erg, input logic [1:0] ewg);
    exp_t e;
    #1;
    chk({tag, "_rd_gnt"}, 64'(rd_gnt), 64'(erg));
    chk({tag, "_wr_gnt"}, 64'(wr_gnt), 64'(ewg));
    for (int i = 0; i < NrRd; i++) begin
      if (erg[i]) begin
        e.due  = cyc + 2;
        e.data = exp_data[i];
        sb[i].push_back(e);
      end
    end
    tick();
  endtask

  initial begin
    rd_req = '0; rd_addr = '0; wr_req = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
    for (int i = 0; i < NrRd; i++) exp_data[i] = '0;
    tick();
    tick();
    chk("reset_bank_req", 64'(bank_req), 64'd0);
    chk("reset_bank_we", 64'(bank_we), 64'd0);
    chk("reset_bank_wdata", bank_wdata[0], 64'd0);
    rst_ni = 1'b1;

    // Single read of 0x05 -> bank 1, row 1.
    rd(0, 8'h05);
    cycle("single", 4'b0001, 2'b00);
    chk("single_bank_req", 64'(bank_req), 64'b0010);
    chk("single_bank_we", 64'(bank_we), 64'd0);
    chk("single_row", 64'(bank_addr[1]), 64'd1);
    idle();
    cycle("single_idle", 4'b0000, 2'b00);
    cycle("single_idle", 4'b0000, 2'b00);

    // Three then four readers on bank 0: rotation and pointer wrap.
    rd(0, 8'h00); rd(1, 8'h04); rd(2, 8'h08);
    cycle("rot3_a", 4'b0001, 2'b00);
    cycle("rot3_b", 4'b0010, 2'b00);
    cycle("rot3_c", 4'b0100, 2'b00);
    cycle("rot3_d", 4'b0001, 2'b00);
    rd(3, 8'h0C);
    cycle("rot4_a", 4'b0010, 2'b00);
    cycle("rot4_b", 4'b0100, 2'b00);
    cycle("rot4_c", 4'b1000, 2'b00);
    cycle("rot4_d", 4'b0001, 2'b00);
    idle();
    cycle("rot_idle", 4'b0000, 2'b00);
    cycle("rot_idle", 4'b0000, 2'b00);

    // Continuous write vs read on bank 2: three writes, then the read.
    wr(0, 8'h02, 64'h1111_2222_3333_4444, 8'hFF);
    rd(1, 8'h06);
    for (int c = 0; c < 8; c++)
      cycle($sformatf("starve%0d", c), (c % 4 == 3) ? 4'b0010 : 4'b0000,
            (c % 4 == 3) ? 2'b00 : 2'b01);
    idle();

    // Two writers on bank 3 alternate.
    wr(0, 8'h03, 64'hA, 8'hFF);
    wr(1, 8'h07, 64'hB, 8'hFF);
    cycle("wrr_a", 4'b0000, 2'b01);
    cycle("wrr_b", 4'b0000, 2'b10);
    cycle("wrr_c", 4'b0000, 2'b01);
    idle();
    cycle("wrr_idle", 4'b0000, 2'b00);
    cycle("wrr_idle", 4'b0000, 2'b00);

    // Write followed by read-after-write; second write uses partial byte enables.
    wr(0, 8'h10, 64'h0000_0000_DEAD_BEEF, 8'hFF);
    wr(1, 8'h15, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
    cycle("raw_wr", 4'b0000, 2'b11);
    chk("raw_bank_we", 64'(bank_we), 64'b0011);
    chk("raw_row", 64'(bank_addr[0]), 64'd4);
    chk("raw_wdata", bank_wdata[0], 64'h0000_0000_DEAD_BEEF);
    chk("raw_be", 64'(bank_be[1]), 64'h0F);
    idle();
    rd(0, 8'h10);
    exp_data[0] = 64'h0000_0000_DEAD_BEEF;
    rd(1, 8'h15);
    w = init_word(8'h15);
    exp_data[1] = {w[63:32], 32'hFFFF_FFFF};
    cycle("raw_rd", 4'b0011, 2'b00);
    idle();
    cycle("raw_idle", 4'b0000, 2'b00);
    cycle("raw_idle", 4'b0000, 2'b00);

    // Four readers, four distinct banks.
    rd(0, 8'h20); rd(1, 8'h21); rd(2, 8'h22); rd(3, 8'h23);
    cycle("quad", 4'b1111, 2'b00);
    chk("quad_bank_req", 64'(bank_req), 64'b1111);
    chk("quad_bank_we", 64'(bank_we), 64'd0);
    idle();
    cycle("quad_idle", 4'b0000, 2'b00);
    cycle("quad_idle", 4'b0000, 2'b00);

    // Build up state (rp[0]=1, starve[2]=2), grant a read, then reset under it.
    wr(0, 8'h0A, 64'h5, 8'hFF); rd(2, 8'h0E); rd(0, 8'h00);
    cycle("pre_a", 4'b0001, 2'b01);
    rd_req[0] = 1'b0;
    cycle("pre_b", 4'b0000, 2'b01);
    idle();
    rd(1, 8'h01);
    cycle("pre_rd", 4'b0010, 2'b00);
    rst_ni = 1'b0;
    idle();
    for (int i = 0; i < NrRd; i++) sb[i].delete();
    #1;
    chk("rst_bank_req", 64'(bank_req), 64'd0);
    chk("rst_rd_valid", 64'(rd_valid), 64'd0);
    tick();
    tick();
    rst_ni = 1'b1;

    // Pointers and starve counters must be back at zero.
    rd(0, 8'h00); rd(1, 8'h04); rd(3, 8'h0C);
    cycle("post_rot", 4'b0001, 2'b00);
    idle();
    wr(0, 8'h0A, 64'h6, 8'hFF); rd(2, 8'h0E);
    cycle("post_st0", 4'b0000, 2'b01);
    cycle("post_st1", 4'b0000, 2'b01);
    cycle("post_st2", 4'b0000, 2'b01);
    cycle("post_st3", 4'b0100, 2'b00);
    idle();
    for (int c = 0; c < 3; c++) cycle("drain", 4'b0000, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
